apb_master: RTL and testbench
=============================

# apb_master

APB requester that turns single-beat commands from an internal valid/ready command port into APB3 SETUP/ACCESS transfers and returns the read data and error status on a one-cycle response strobe. It sits between on-chip control logic (test sequencer, configuration engine) and APB completers on the same bus. It also bounds each transfer with a wait-state timeout so a non-responding completer cannot hang the requester.

## Interface
- TIMEOUT, default 16: maximum number of ACCESS cycles without pready before the transfer is aborted; legal range ≥1.
- pclk  input  1  APB clock; all logic is on its rising edge.
- prst  input  1  reset, synchronous and active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  transfer address.
- cmd_wdata  input  32  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse marking transfer completion.
- rsp_rdata  output  32  read data; 0 for writes and timeouts.
- rsp_err  output  1  completer error or timeout; valid with rsp_valid.
- rsp_timeout  output  1  transfer aborted by timeout; valid with rsp_valid.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  32  APB address.
- pwdata  output  32  APB write data.
- prdata  input  32  APB read data.
- pready  input  1  completer ready.
- pslverr  input  1  completer error, sampled only with pready.

## Operation
- States: IDLE, SETUP, ACCESS.
- cmd_ready = (state == IDLE) && !prst. This is combinational from the registered state.
- IDLE, on accept: register cmd_write, cmd_addr and cmd_wdata onto pwrite, paddr and pwdata. Set psel <= 1, penable <= 0, go to SETUP.
- SETUP: lasts exactly one cycle. Set penable <= 1, clear the wait counter, go to ACCESS.
- ACCESS with pready = 1:
  - Set psel <= 0 and penable <= 0.
  - Set rsp_valid <= 1 and rsp_err <= pslverr.
  - Set rsp_rdata <= prdata for a read, 0 for a write.
  - Set rsp_timeout <= 0 and go to IDLE.
- ACCESS with pready = 0:
  - If the wait counter equals TIMEOUT-1: set psel <= 0, penable <= 0, rsp_valid <= 1, rsp_err <= 1, rsp_timeout <= 1, rsp_rdata <= 0, go to IDLE.
  - Otherwise increment the counter.
- Wait counter width is $clog2(TIMEOUT+1). It never wraps.
- rsp_valid is high for exactly one cycle per accepted command. There is no response backpressure.
- rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- paddr, pwrite and pwdata stay constant from SETUP through the last ACCESS cycle. They keep their last values while idle.
- psel never deasserts mid-transfer except on completion, timeout or reset.

## Timing
- Reset: while prst is high at an edge, the next state is IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err and rsp_timeout are all 0.
  - The wait counter is 0.
  - cmd_ready is 0 during reset and 1 in the first cycle after prst falls.
- Reset mid-transfer: the bus drops to idle at the next edge. No rsp_valid is produced and the command is lost.
- Accept at edge E0. SETUP is the cycle after E0 (psel=1, penable=0). The first ACCESS cycle follows (psel=1, penable=1).
- Zero-wait completer: pready is sampled high at the end of the first ACCESS cycle. rsp_valid is high in the next cycle. Transfer cost is 3 cycles from accept to response.
- A completer with a registered pready adds one wait state; this is legal.
- Each wait state adds one ACCESS cycle. ACCESS lasts at most TIMEOUT cycles.
- pready = 1 in the TIMEOUT-th ACCESS cycle wins over timeout and gives a normal completion.
- Back-to-back: cmd_ready is high in the same cycle as rsp_valid. A new command can be accepted there, giving one idle bus cycle (psel=0) between transfers.
- pslverr and prdata are ignored in cycles where pready = 0 or state != ACCESS.

## Test plan
- Reset: hold prst for 2 cycles mid-idle → every output is 0 and cmd_ready is 0. One cycle after release, cmd_ready = 1.
- Zero-wait write: cmd addr 0x4, data 0xDEADBEEF; completer drives pready in the first ACCESS cycle.
  - psel is high for 2 cycles, penable only in the second, paddr = 0x4 and pwdata = 0xDEADBEEF stable throughout.
  - rsp_valid pulses once with rsp_err = 0 and rsp_rdata = 0.
- Read with 2 wait states: addr 0x4; pready rises in the third ACCESS cycle with prdata = 0xDEADBEEF.
  - psel, penable and paddr are stable for all 3 ACCESS cycles.
  - rsp_rdata = 0xDEADBEEF and rsp_err = 0.
- Completer error: read addr 0x40 with pready = 1 and pslverr = 1 → rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0x40 bus prdata value.
- Timeout with TIMEOUT = 16 and pready held at 0 → exactly 16 ACCESS cycles, then psel = 0 and rsp_valid with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Repeat with pready arriving in ACCESS cycle 16 → normal completion with rsp_timeout = 0.
- Back-to-back and reset mid-transfer:
  - Two commands with cmd_valid held high → second accept in the rsp_valid cycle and exactly one psel=0 gap cycle.
  - Assert prst in ACCESS → psel and penable are 0 at the next edge and no rsp_valid is produced.

Source files
------------

// File: rtl/apb_master_if.sv
// Command/response port and APB3 bus of the APB requester, bundled as one interface.
interface apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  // Requester side: accepts commands, drives the APB bus, returns responses.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  // Environment side: issues commands, consumes responses, acts as completer.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB3 requester: single-beat valid/ready commands become SETUP/ACCESS
// transfers; completion, completer error or wait-state timeout is reported
// on a one-cycle response strobe.
module apb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic   pclk,
  input  logic   prst,
  apb_master_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;

  logic             accept;
  logic             psel_nxt;
  logic             penable_nxt;
  logic             pwrite_nxt;
  logic [31:0]      paddr_nxt;
  logic [31:0]      pwdata_nxt;
  logic             rsp_valid_nxt;
  logic [31:0]      rsp_rdata_nxt;
  logic             rsp_err_nxt;
  logic             rsp_timeout_nxt;

  // Commands are only taken while idle and out of reset.
  assign bus.cmd_ready = (state == IDLE) && !prst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // State and all bus/response registers; reset returns the bus to idle and
  // silently drops any transfer in flight.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      state           <= state_nxt;
      wait_cnt        <= wait_cnt_nxt;
      bus.psel        <= psel_nxt;
      bus.penable     <= penable_nxt;
      bus.pwrite      <= pwrite_nxt;
      bus.paddr       <= paddr_nxt;
      bus.pwdata      <= pwdata_nxt;
      bus.rsp_valid   <= rsp_valid_nxt;
      bus.rsp_rdata   <= rsp_rdata_nxt;
      bus.rsp_err     <= rsp_err_nxt;
      bus.rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // Next-state: SETUP is always one cycle; ACCESS ends on pready or when the
  // wait budget is spent (pready takes priority in the last allowed cycle).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.pready || (wait_cnt == CNT_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless the
  // current state says otherwise, and the response strobe defaults low.
  always_comb begin
    psel_nxt        = bus.psel;
    penable_nxt     = bus.penable;
    pwrite_nxt      = bus.pwrite;
    paddr_nxt       = bus.paddr;
    pwdata_nxt      = bus.pwdata;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = bus.rsp_rdata;
    rsp_err_nxt     = bus.rsp_err;
    rsp_timeout_nxt = bus.rsp_timeout;
    wait_cnt_nxt    = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          pwrite_nxt  = bus.cmd_write;
          paddr_nxt   = bus.cmd_addr;
          pwdata_nxt  = bus.cmd_wdata;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
        end
      end
      SETUP: begin
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
      end
      ACCESS: begin
        if (bus.pready) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = bus.pslverr;
          rsp_rdata_nxt   = bus.pwrite ? 32'd0 : bus.prdata;
          rsp_timeout_nxt = 1'b0;
        end else if (wait_cnt == CNT_LAST) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_rdata_nxt   = 32'd0;
          rsp_timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed testbench for apb_master with hand-computed expected values.
module tb_apb_master;

  logic pclk;
  logic prst;
  int   vectors;
  int   miscompares;

  apb_master_if bus();

  apb_master #(.TIMEOUT(16)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    prst = 1'b1;
    cyc();
    cyc();
    vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready got=%b want=0", bus.cmd_ready); end
    vectors++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) begin miscompares++; $display("FAIL rst_bus_ctrl got=%b want=000", {bus.psel, bus.penable, bus.pwrite}); end
    vectors++; if ({bus.paddr, bus.pwdata} !== 64'd0) begin miscompares++; $display("FAIL rst_addr_data got=%h want=0", {bus.paddr, bus.pwdata}); end
    vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== 35'd0) begin miscompares++; $display("FAIL rst_rsp got=%h want=0", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}); end
    prst = 1'b0;
    cyc();
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready got=%b want=1", bus.cmd_ready); end
  endtask

  task automatic issue(input logic write, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = write;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL issue_ready got=%b want=1", bus.cmd_ready); end
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_zero_wait_write();
    bus.pready = 1'b0;
    issue(1'b1, 32'h4, 32'hDEADBEEF);
    vectors++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b101) begin miscompares++; $display("FAIL wr_setup_ctrl got=%b want=101", {bus.psel, bus.penable, bus.pwrite}); end
    vectors++; if ({bus.paddr, bus.pwdata} !== {32'h4, 32'hDEADBEEF}) begin miscompares++; $display("FAIL wr_setup_addr_data got=%h want=%h", {bus.paddr, bus.pwdata}, {32'h4, 32'hDEADBEEF}); end
    bus.pready = 1'b1;
    cyc();
    vectors++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin miscompares++; $display("FAIL wr_access_ctrl got=%b want=110", {bus.psel, bus.penable, bus.rsp_valid}); end
    vectors++; if ({bus.paddr, bus.pwdata} !== {32'h4, 32'hDEADBEEF}) begin miscompares++; $display("FAIL wr_access_addr_data got=%h want=%h", {bus.paddr, bus.pwdata}, {32'h4, 32'hDEADBEEF}); end
    cyc();
    bus.pready = 1'b0;
    vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel, bus.penable} !== 5'b10000) begin miscompares++; $display("FAIL wr_rsp_flags got=%b want=10000", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel, bus.penable}); end
    vectors++; if (bus.rsp_rdata !== 32'd0) begin miscompares++; $display("FAIL wr_rsp_rdata got=%h want=0", bus.rsp_rdata); end
    cyc();
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_single_pulse got=%b want=0", bus.rsp_valid); end
    vectors++; if ({bus.paddr, bus.pwdata} !== {32'h4, 32'hDEADBEEF}) begin miscompares++; $display("FAIL wr_idle_hold got=%h want=%h", {bus.paddr, bus.pwdata}, {32'h4, 32'hDEADBEEF}); end
  endtask

  task automatic test_read_wait2();
    bus.pready = 1'b0;
    bus.prdata = 32'h0BAD0BAD;
    issue(1'b0, 32'h4, 32'h0);
    vectors++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b100) begin miscompares++; $display("FAIL rd_setup_ctrl got=%b want=100", {bus.psel, bus.penable, bus.pwrite}); end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 3) begin
        bus.pready = 1'b1;
        bus.prdata = 32'hDEADBEEF;
      end
      vectors++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin miscompares++; $display("FAIL rd_access%0d_ctrl got=%b want=110", k, {bus.psel, bus.penable, bus.rsp_valid}); end
      vectors++; if (bus.paddr !== 32'h4) begin miscompares++; $display("FAIL rd_access%0d_addr got=%h want=00000004", k, bus.paddr); end
    end
    cyc();
    bus.pready = 1'b0;
    bus.prdata = 32'h12345678;
    vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel} !== 4'b1000) begin miscompares++; $display("FAIL rd_rsp_flags got=%b want=1000", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel}); end
    vectors++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_rsp_rdata got=%h want=deadbeef", bus.rsp_rdata); end
    cyc();
    vectors++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_rsp_hold got=%h want=deadbeef", bus.rsp_rdata); end
  endtask

  task automatic test_slverr();
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'h40;
    issue(1'b0, 32'h40, 32'h0);
    cyc();
    cyc();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b110) begin miscompares++; $display("FAIL err_rsp_flags got=%b want=110", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}); end
    vectors++; if (bus.rsp_rdata !== 32'h40) begin miscompares++; $display("FAIL err_rsp_rdata got=%h want=00000040", bus.rsp_rdata); end
  endtask

  // arrive = ACCESS cycle number in which pready rises, 0 for never.
  task automatic test_timeout(input int arrive);
    int  n;
    bit  resp;
    n    = 0;
    resp = 1'b0;
    bus.pready = 1'b0;
    bus.prdata = 32'hCAFEF00D;
    issue(1'b0, 32'h80, 32'h0);
    for (int i = 0; i < 40 && !resp; i++) begin
      cyc();
      if (bus.rsp_valid) resp = 1'b1;
      else if (bus.psel && bus.penable) begin
        n++;
        if (arrive != 0 && n == arrive) bus.pready = 1'b1;
      end
    end
    bus.pready = 1'b0;
    vectors++; if (resp !== 1'b1) begin miscompares++; $display("FAIL to%0d_rsp_seen got=%b want=1", arrive, resp); end
    vectors++; if (n != 16) begin miscompares++; $display("FAIL to%0d_access_cycles got=%0d want=16", arrive, n); end
    if (arrive == 0) begin
      vectors++; if ({bus.rsp_err, bus.rsp_timeout, bus.psel} !== 3'b110) begin miscompares++; $display("FAIL to_abort_flags got=%b want=110", {bus.rsp_err, bus.rsp_timeout, bus.psel}); end
      vectors++; if (bus.rsp_rdata !== 32'd0) begin miscompares++; $display("FAIL to_abort_rdata got=%h want=0", bus.rsp_rdata); end
    end else begin
      vectors++; if ({bus.rsp_err, bus.rsp_timeout, bus.psel} !== 3'b000) begin miscompares++; $display("FAIL to_late_flags got=%b want=000", {bus.rsp_err, bus.rsp_timeout, bus.psel}); end
      vectors++; if (bus.rsp_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL to_late_rdata got=%h want=cafef00d", bus.rsp_rdata); end
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    bus.pready    = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h100;
    bus.cmd_wdata = 32'h11111111;
    cyc();
    bus.cmd_addr  = 32'h104;
    bus.cmd_wdata = 32'h22222222;
    vectors++; if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b100) begin miscompares++; $display("FAIL b2b_setup1 got=%b want=100", {bus.psel, bus.penable, bus.cmd_ready}); end
    vectors++; if (bus.paddr !== 32'h100) begin miscompares++; $display("FAIL b2b_addr1 got=%h want=00000100", bus.paddr); end
    cyc();
    vectors++; if ({bus.psel, bus.penable} !== 2'b11) begin miscompares++; $display("FAIL b2b_access1 got=%b want=11", {bus.psel, bus.penable}); end
    cyc();
    vectors++; if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 3'b110) begin miscompares++; $display("FAIL b2b_rsp1_gap got=%b want=110", {bus.rsp_valid, bus.cmd_ready, bus.psel}); end
    cyc();
    bus.cmd_valid = 1'b0;
    vectors++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b100) begin miscompares++; $display("FAIL b2b_setup2 got=%b want=100", {bus.psel, bus.penable, bus.rsp_valid}); end
    vectors++; if ({bus.paddr, bus.pwdata} !== {32'h104, 32'h22222222}) begin miscompares++; $display("FAIL b2b_addr2 got=%h want=%h", {bus.paddr, bus.pwdata}, {32'h104, 32'h22222222}); end
    cyc();
    cyc();
    bus.pready = 1'b0;
    vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.psel} !== 3'b100) begin miscompares++; $display("FAIL b2b_rsp2 got=%b want=100", {bus.rsp_valid, bus.rsp_err, bus.psel}); end
    cyc();
  endtask

  task automatic test_reset_mid_transfer();
    int pulses;
    pulses = 0;
    bus.pready = 1'b0;
    issue(1'b0, 32'h200, 32'h0);
    cyc();
    vectors++; if ({bus.psel, bus.penable} !== 2'b11) begin miscompares++; $display("FAIL rmid_access got=%b want=11", {bus.psel, bus.penable}); end
    prst = 1'b1;
    cyc();
    vectors++; if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin miscompares++; $display("FAIL rmid_drop got=%b want=0000", {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}); end
    prst = 1'b0;
    bus.pready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.rsp_valid) pulses++;
    end
    bus.pready = 1'b0;
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rmid_no_rsp got=%0d want=0", pulses); end
    vectors++; if ({bus.cmd_ready, bus.psel} !== 2'b10) begin miscompares++; $display("FAIL rmid_idle got=%b want=10", {bus.cmd_ready, bus.psel}); end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    prst          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.prdata    = 32'h0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_reset();
    test_read_wait2();
    test_slverr();
    test_timeout(0);
    test_timeout(16);
    test_back_to_back();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
